// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and the fetch-queue entry record
package mips_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
    } fetchEntry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// rtl/fetch_queue_mem.sv - DEPTH-entry register array, one write port, one async read port
module fetch_queue_mem
    import mips_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type entryT = fetchEntry_t,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wrEn,
    input  logic [PTR_W-1:0] wrAddr,
    input  entryT            wrData,
    input  logic [PTR_W-1:0] rdAddr,
    output entryT            rdData
);

    // Contents are only observable through count != 0, so no reset is needed.
    entryT slots [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            slots[wrAddr] <= wrData;
        end
    end

    assign rdData = slots[rdAddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction queue; optional same-cycle bypass via FETCH_QUEUE_BYPASS_EN
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flushFD,
    input  logic             validF,
    input  logic [WIDTH-1:0] instrF,
    input  logic [WIDTH-1:0] pcF,
    input  logic [WIDTH-1:0] pcplus4F,
    output logic             fullF,
    input  logic             stallD,
    output logic             validD,
    output logic [WIDTH-1:0] instrD,
    output logic [WIDTH-1:0] pcD,
    output logic [WIDTH-1:0] pcplus4D
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Same layout as fetchEntry_t, sized to this instance's WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] pcplus4;
    } entryT;

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             doPush;
    logic             doPop;
    entryT            fEntry;
    entryT            headEntry;
    entryT            outEntry;

    assign fEntry = '{instr: instrF, pc: pcF, pcplus4: pcplus4F};
    assign fullF  = (count == CNT_W'(DEPTH));

    fetch_queue_mem #(
        .DEPTH  (DEPTH),
        .entryT (entryT)
    ) u_mem (
        .clk    (clk),
        .wrEn   (doPush),
        .wrAddr (wrPtr),
        .wrData (fEntry),
        .rdAddr (rdPtr),
        .rdData (headEntry)
    );

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass = (count == '0) && validF && !flushFD;

    always_comb begin
        validD   = (count != '0) || bypass;
        outEntry = bypass ? fEntry : headEntry;
    end

    // A bypassed word that decode takes immediately never touches storage.
    assign doPush = validF && !fullF && !flushFD && !(bypass && !stallD);
    assign doPop  = (count != '0) && !stallD;
`else
    always_comb begin
        validD   = (count != '0);
        outEntry = headEntry;
    end

    assign doPush = validF && !fullF && !flushFD;
    assign doPop  = validD && !stallD;
`endif

    always_comb begin
        instrD   = WIDTH'(NOP);
        pcD      = '0;
        pcplus4D = '0;
        if (validD) begin
            instrD   = outEntry.instr;
            pcD      = outEntry.pc;
            pcplus4D = outEntry.pcplus4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else if (flushFD) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else begin
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
        end
    end

endmodule
